// File: rtl/ep0_in_sender.sv
// EP0 IN data-stage transmitter: streams a ROM region as max-packet DATA packets with toggle, retry and ZLP.
// Optional feature: define EP0_IN_ZLP_EN to terminate exact-multiple short transfers with a zero-length packet.
module ep0_in_sender #(
   parameter int MAX_PKT = 8,
   parameter int ADDR_W  = 8
) (
   input  logic              clk48,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [15:0]       src_len,
   input  logic [15:0]       req_len,
   input  logic              abort,
   input  logic              in_token,
   input  logic              ack_in,
   input  logic              txn_timeout,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              tx_last,
   output logic              tx_zlp,
   output logic              tx_pid,
   output logic              busy,
   output logic              done
);

   localparam logic [15:0] PKT_MAX = 16'(MAX_PKT);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_TOKEN, S_FETCH, S_SEND, S_WAIT_ACK, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [ADDR_W-1:0] pkt_base_q, pkt_base_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_valid_q, tx_valid_d;
   logic              tx_last_q, tx_last_d;
   logic              tx_zlp_q, tx_zlp_d;
   logic              tx_pid_q, tx_pid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              zlp_owed_q, zlp_owed_d;
   logic [15:0]       remaining_q, remaining_d;
   logic [15:0]       byte_cnt_q, byte_cnt_d;

   logic [15:0]       xfer_len_c, pkt_len_c, rem_after_c;
   logic [ADDR_W-1:0] base_after_c;
   logic              zlp_need_c, zlp_left_c;

   // Transfer sizing and per-packet bookkeeping
   always_comb begin
      xfer_len_c = (src_len < req_len) ? src_len : req_len;
`ifdef EP0_IN_ZLP_EN
      zlp_need_c = (xfer_len_c < req_len) && ((xfer_len_c & (PKT_MAX - 16'd1)) == 16'd0);
`else
      zlp_need_c = 1'b0;
`endif
      pkt_len_c    = (remaining_q < PKT_MAX) ? remaining_q : PKT_MAX;
      rem_after_c  = remaining_q - pkt_len_c;
      base_after_c = pkt_base_q + ADDR_W'(pkt_len_c);
      // an ACKed zero-length packet settles the owed ZLP
      zlp_left_c   = (pkt_len_c == 16'd0) ? 1'b0 : zlp_owed_q;
   end

   always_comb begin
      state_d     = state_q;
      rom_addr_d  = rom_addr_q;
      pkt_base_d  = pkt_base_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      tx_last_d   = tx_last_q;
      tx_zlp_d    = 1'b0;
      tx_pid_d    = tx_pid_q;
      done_d      = 1'b0;
      zlp_owed_d  = zlp_owed_q;
      remaining_d = remaining_q;
      byte_cnt_d  = byte_cnt_q;

      if (abort) begin
         state_d    = S_IDLE;
         tx_valid_d = 1'b0;
         tx_last_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d     = S_WAIT_TOKEN;
                  remaining_d = xfer_len_c;
                  pkt_base_d  = src_addr;
                  rom_addr_d  = src_addr;
                  tx_pid_d    = 1'b1;
                  zlp_owed_d  = zlp_need_c;
               end
            end
            S_WAIT_TOKEN: begin
               if (in_token) begin
                  if (pkt_len_c != 16'd0) begin
                     state_d    = S_FETCH;
                     byte_cnt_d = 16'd0;
                     rom_addr_d = pkt_base_q;
                  end else begin
                     state_d  = S_WAIT_ACK;
                     tx_zlp_d = 1'b1;
                  end
               end
            end
            S_FETCH: state_d = S_SEND;
            S_SEND: begin
               // first SEND cycle captures ROM output, then hold until accepted
               if (!tx_valid_q) begin
                  tx_data_d  = rom_data;
                  tx_valid_d = 1'b1;
                  tx_last_d  = ((byte_cnt_q + 16'd1) == pkt_len_c);
               end else if (tx_ready) begin
                  tx_valid_d = 1'b0;
                  tx_last_d  = 1'b0;
                  rom_addr_d = rom_addr_q + ADDR_W'(1);
                  byte_cnt_d = byte_cnt_q + 16'd1;
                  state_d    = tx_last_q ? S_WAIT_ACK : S_FETCH;
               end
            end
            S_WAIT_ACK: begin
               if (ack_in) begin
                  tx_pid_d    = ~tx_pid_q;
                  pkt_base_d  = base_after_c;
                  rom_addr_d  = base_after_c;
                  remaining_d = rem_after_c;
                  zlp_owed_d  = zlp_left_c;
                  if ((rem_after_c == 16'd0) && !zlp_left_c) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_WAIT_TOKEN;
                  end
               end else if (txn_timeout) begin
                  rom_addr_d = pkt_base_q;
                  state_d    = S_WAIT_TOKEN;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk48 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         rom_addr_q  <= '0;
         pkt_base_q  <= '0;
         tx_data_q   <= 8'd0;
         tx_valid_q  <= 1'b0;
         tx_last_q   <= 1'b0;
         tx_zlp_q    <= 1'b0;
         tx_pid_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         zlp_owed_q  <= 1'b0;
         remaining_q <= 16'd0;
         byte_cnt_q  <= 16'd0;
      end else begin
         state_q     <= state_d;
         rom_addr_q  <= rom_addr_d;
         pkt_base_q  <= pkt_base_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         tx_last_q   <= tx_last_d;
         tx_zlp_q    <= tx_zlp_d;
         tx_pid_q    <= tx_pid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         zlp_owed_q  <= zlp_owed_d;
         remaining_q <= remaining_d;
         byte_cnt_q  <= byte_cnt_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign tx_last  = tx_last_q;
   assign tx_zlp   = tx_zlp_q;
   assign tx_pid   = tx_pid_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_ep0_in_sender.sv
// Bench for ep0_in_sender: table of transfers driven by a host model, packets scored against a queue.
module tb_ep0_in_sender;

   localparam int MAX_PKT = 8;
   localparam int ADDR_W  = 8;

   logic              clk48 = 1'b0;
   logic              reset_n;
   logic              start, abort, in_token, ack_in, txn_timeout, tx_ready;
   logic [ADDR_W-1:0] src_addr, rom_addr;
   logic [15:0]       src_len, req_len;
   logic [7:0]        rom_data, tx_data;
   logic              tx_valid, tx_last, tx_zlp, tx_pid, busy, done;

   always #5 clk48 = ~clk48;

   ep0_in_sender #(.MAX_PKT(MAX_PKT), .ADDR_W(ADDR_W)) dut (
      .clk48(clk48), .reset_n(reset_n), .start(start), .src_addr(src_addr),
      .src_len(src_len), .req_len(req_len), .abort(abort), .in_token(in_token),
      .ack_in(ack_in), .txn_timeout(txn_timeout), .rom_addr(rom_addr),
      .rom_data(rom_data), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_last(tx_last), .tx_zlp(tx_zlp), .tx_pid(tx_pid),
      .busy(busy), .done(done)
   );

   // Synchronous ROM: data for rom_addr appears one cycle later
   logic [7:0] rom_mem [256];
   always @(posedge clk48) rom_data <= rom_mem[rom_addr];

   typedef struct { logic zlp; logic [7:0] data; logic last; logic pid; } exp_t;
   typedef struct {
      logic [7:0] addr; logic [15:0] src_len; logic [15:0] req_len;
      int to_round; int exp_ends; int exp_zlps;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[9];
   int   checks = 0, failures = 0;
   int   accepts = 0, ends = 0, zlps = 0, dones = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic monitor();
      logic held = 1'b0, skip = 1'b1, hl = 1'b0;
      logic [7:0] hd = 8'd0;
      exp_t e;
      forever begin
         @(negedge clk48);
         if (!reset_n || abort) begin
            skip = 1'b1;
            held = 1'b0;
         end else begin
            if (held && !skip) begin
               chk("hold_valid", 32'(tx_valid), 32'd1);
               chk("hold_data_last", {tx_last, tx_data}, {hl, hd});
            end
            skip = 1'b0;
            if (tx_valid && tx_ready) begin
               accepts++;
               chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("byte_zlp_data_last_pid", {1'b0, tx_data, tx_last, tx_pid},
                      {e.zlp, e.data, e.last, e.pid});
               end
               if (tx_last) ends++;
            end
            if (tx_zlp) begin
               zlps++;
               ends++;
               chk("zlp_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("zlp_pid_novalid", {1'b1, tx_pid, tx_valid}, {e.zlp, e.pid, 1'b0});
               end
            end
            if (done) dones++;
            held = tx_valid && !tx_ready;
            hd   = tx_data;
            hl   = tx_last;
         end
      end
   endtask

   task automatic ready_gen();
      forever begin
         @(posedge clk48);
         #1 tx_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic pulse_in();    @(posedge clk48); #1 in_token = 1'b1;    @(posedge clk48); #1 in_token = 1'b0;    endtask
   task automatic pulse_ack();   @(posedge clk48); #1 ack_in = 1'b1;      @(posedge clk48); #1 ack_in = 1'b0;      endtask
   task automatic pulse_to();    @(posedge clk48); #1 txn_timeout = 1'b1; @(posedge clk48); #1 txn_timeout = 1'b0; endtask
   task automatic pulse_abort(); @(posedge clk48); #1 abort = 1'b1;       @(posedge clk48); #1 abort = 1'b0;       endtask

   task automatic do_start(input logic [7:0] a, input logic [15:0] sl, input logic [15:0] rl);
      @(posedge clk48);
      #1 start = 1'b1; src_addr = a; src_len = sl; req_len = rl;
      @(posedge clk48);
      #1 start = 1'b0;
      @(negedge clk48);
      chk("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic push_pkt(input logic [7:0] base, input int plen, input logic pid);
      exp_t e;
      if (plen == 0) begin
         e = '{zlp: 1'b1, data: 8'd0, last: 1'b0, pid: pid};
         exp_q.push_back(e);
      end
      for (int j = 0; j < plen; j++) begin
         e = '{zlp: 1'b0, data: rom_mem[8'(int'(base) + j)], last: (j == plen - 1), pid: pid};
         exp_q.push_back(e);
      end
   endtask

   // Bounded wait until the monitor's end (sel=0) or accept (sel=1) count reaches target
   task automatic wait_for(input bit sel, input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ((sel ? accepts : ends) >= target) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk48);
         #2;
      end
      if (!ok) chk(sel ? "wait_accepts" : "wait_packet_end", sel ? accepts : ends, target);
   endtask

   task automatic run_xfer(input vec_t v);
      int   e_s = ends, z_s = zlps, d_s = dones;
      int   rem, plen, round = 0, iter = 0;
      logic [7:0] base = v.addr;
      logic pid = 1'b1, owed, exp_done;
      bit   ok, fin = 1'b0, timed = 1'b0;
      rem = (v.src_len < v.req_len) ? int'(v.src_len) : int'(v.req_len);
`ifdef EP0_IN_ZLP_EN
      owed = (rem < int'(v.req_len)) && (rem % MAX_PKT == 0);
`else
      owed = 1'b0;
`endif
      do_start(v.addr, v.src_len, v.req_len);
      while (!fin && iter < 20) begin
         iter++;
         plen = (rem < MAX_PKT) ? rem : MAX_PKT;
         push_pkt(base, plen, pid);
         pulse_in();
         wait_for(1'b0, ends + 1, ok);
         if (!ok) begin
            pulse_abort();
            exp_q.delete();
            break;
         end
         if (round == v.to_round && !timed) begin
            timed = 1'b1;
            pulse_to();
            @(negedge clk48);
            chk("done_after_timeout", 32'(done), 32'd0);
         end else begin
            pid  = ~pid;
            base = 8'(int'(base) + plen);
            rem  = rem - plen;
            if (plen == 0) owed = 1'b0;
            exp_done = (rem == 0) && !owed;
            pulse_ack();
            @(negedge clk48);
            chk("done_after_ack", 32'(done), 32'(exp_done));
            @(negedge clk48);
            chk("busy_after_ack", 32'(busy), 32'(!exp_done));
            fin = exp_done;
            round++;
         end
      end
      chk("packet_ends", ends - e_s, v.exp_ends);
      chk("zlp_count", zlps - z_s, v.exp_zlps);
      chk("done_count", dones - d_s, 1);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int a0, lat;
      vec_t v;
      for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i);
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; in_token = 1'b0; ack_in = 1'b0;
      txn_timeout = 1'b0; tx_ready = 1'b0; src_addr = '0; src_len = '0; req_len = '0;

      vecs[0] = '{8'h00, 16'd18,  16'd64, -1, 3, 0};
`ifdef EP0_IN_ZLP_EN
      vecs[1] = '{8'h00, 16'd16,  16'd64, -1, 3, 1};
`else
      vecs[1] = '{8'h00, 16'd16,  16'd64, -1, 2, 0};
`endif
      vecs[2] = '{8'h00, 16'd16,  16'd16, -1, 2, 0};
      vecs[3] = '{8'h00, 16'd12,  16'd12,  0, 3, 0};
      vecs[4] = '{8'hFC, 16'd10,  16'd9,  -1, 2, 0};
      vecs[5] = '{8'h20, 16'd0,   16'd0,  -1, 1, 1};
      vecs[6] = '{8'h20, 16'd5,   16'd0,  -1, 1, 1};
      vecs[7] = '{8'h40, 16'd100, 16'd8,  -1, 1, 0};
      vecs[8] = '{8'h00, 16'd0,   16'd64, -1, 1, 1};

      fork
         monitor();
         ready_gen();
      join_none

      repeat (3) @(negedge clk48);
      chk("reset_outputs", {rom_addr, tx_data, tx_valid, tx_last, tx_zlp, tx_pid, busy, done}, 32'd0);
      reset_n = 1'b1;

      // IN token while idle must be ignored
      a0 = accepts + ends;
      pulse_in();
      repeat (6) @(negedge clk48);
      chk("idle_token_ignored", accepts + ends, a0);
      chk("idle_not_busy", 32'(busy), 32'd0);

      foreach (vecs[i]) run_xfer(vecs[i]);

      // Abort in the middle of packet 2, then a fresh transfer restarts at DATA1
      do_start(8'h00, 16'd18, 16'd64);
      push_pkt(8'h00, 8, 1'b1);
      pulse_in();
      wait_for(1'b0, ends + 1, ok);
      pulse_ack();
      @(negedge clk48);
      chk("abort_seq_no_early_done", 32'(done), 32'd0);
      push_pkt(8'h08, 8, 1'b0);
      a0 = accepts;
      pulse_in();
      wait_for(1'b1, a0 + 3, ok);
      pulse_abort();
      @(negedge clk48);
      chk("abort_valid_low", 32'(tx_valid), 32'd0);
      chk("abort_not_busy", 32'(busy), 32'd0);
      exp_q.delete();
      a0 = dones;
      repeat (5) @(negedge clk48);
      chk("abort_no_done", dones, a0);
      v = '{8'h10, 16'd4, 16'd4, -1, 1, 0};
      run_xfer(v);

      // Latency check, then asynchronous reset mid-packet
      do_start(8'h00, 16'd12, 16'd12);
      push_pkt(8'h00, 8, 1'b1);
      pulse_in();
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk48);
         lat++;
         if (tx_valid) break;
      end
      chk("token_to_valid_negedges", lat, 3);
      wait_for(1'b1, accepts + 2, ok);
      @(posedge clk48);
      #3 reset_n = 1'b0;
      #1 chk("async_reset_outputs",
             {rom_addr, tx_data, tx_valid, tx_last, tx_zlp, tx_pid, busy, done}, 32'd0);
      exp_q.delete();
      @(negedge clk48);
      reset_n = 1'b1;
      a0 = accepts + ends;
      pulse_in();
      repeat (6) @(negedge clk48);
      chk("post_reset_token_ignored", accepts + ends, a0);
      chk("post_reset_not_busy", 32'(busy), 32'd0);
      run_xfer(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
